// File: rtl/sme_multi_match_if.sv
// Character-load and result-stream bundle for sme_multi_match.
// master = character source / result consumer side, slave = the engine.
interface sme_multi_match_if #(
    parameter int BYTE    = 8,
    parameter int STR_ADD = 5
);
    logic [BYTE-1:0]    chardata;
    logic               isstring;
    logic               ispattern;
    logic               o_ready;
    logic               o_valid;
    logic               match;
    logic [STR_ADD-1:0] match_index;
    logic               o_last;
    logic               busy;

    modport master (
        output chardata, isstring, ispattern, o_ready,
        input  o_valid, match, match_index, o_last, busy
    );

    modport slave (
        input  chardata, isstring, ispattern, o_ready,
        output o_valid, match, match_index, o_last, busy
    );
endinterface

// File: rtl/sme_multi_match.sv
// Multi-result string matcher: serial load, NUM_PE parallel start positions per scan
// cycle, one beat per match then a count beat. Define SME_WILDCARD_EN to make '.' a wildcard.
module sme_multi_match #(
    parameter int BYTE        = 8,
    parameter int MAX_STRING  = 32,
    parameter int MAX_PATTERN = 8,
    parameter int NUM_PE      = 4,
    parameter int STR_ADD     = 5
) (
    input  logic               clk,
    input  logic               reset,
    sme_multi_match_if.slave   bus
);
    localparam int SW = STR_ADD + 1;
    localparam int PW = $clog2(MAX_PATTERN + 1);
    localparam int PA = $clog2(MAX_PATTERN);
    localparam int CW = STR_ADD + 3;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_TERM = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE-1:0]     str_q [MAX_STRING];
    logic [BYTE-1:0]     str_d [MAX_STRING];
    logic [BYTE-1:0]     pat_q [MAX_PATTERN];
    logic [BYTE-1:0]     pat_d [MAX_PATTERN];
    logic [SW-1:0]       slen_q, slen_d;
    logic [PW-1:0]       plen_q, plen_d;
    logic [CW-1:0]       b_q, b_d;
    logic [STR_ADD-1:0]  count_q, count_d, count_inc_s;
    logic [NUM_PE-1:0]   hit_q, hit_d, scan_hit_s, hit_rem_s;
    logic                o_valid_q, o_valid_d, match_q, match_d, o_last_q, o_last_d;
    logic                busy_q, busy_d;
    logic [STR_ADD-1:0]  match_index_q, match_index_d;
    logic                handshake_s, last_group_s;

    function automatic logic char_eq(input logic [BYTE-1:0] s, input logic [BYTE-1:0] p);
`ifdef SME_WILDCARD_EN
        return (p == BYTE'(8'h2E)) || (s == p);
`else
        return (s == p);
`endif
    endfunction

    function automatic logic [CW-1:0] lowest_set(input logic [NUM_PE-1:0] v);
        logic [CW-1:0] r;
        r = CW'(0);
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (v[k]) r = CW'(k);
            else      r = r;
        end
        return r;
    endfunction

    // Parallel comparators: PE k tests start position b+k against the whole pattern
    always_comb begin : pe_compare
        logic [CW-1:0] pos;
        logic [CW-1:0] cidx;
        logic          ok;
        pos        = CW'(0);
        cidx       = CW'(0);
        ok         = 1'b0;
        scan_hit_s = NUM_PE'(0);
        for (int k = 0; k < NUM_PE; k++) begin
            pos = b_q + CW'(k);
            ok  = ((pos + CW'(plen_q)) <= CW'(slen_q));
            for (int j = 0; j < MAX_PATTERN; j++) begin
                cidx = pos + CW'(j);
                if ((PW'(j) < plen_q) && (cidx >= CW'(MAX_STRING))) begin
                    ok = 1'b0;
                end else if ((PW'(j) < plen_q) && !char_eq(str_q[cidx[STR_ADD-1:0]], pat_q[j])) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
            scan_hit_s[k] = ok;
        end
    end

    // Next-state and next-output computation for the load/scan/emit/term sequence
    always_comb begin
        state_d       = state_q;
        str_d         = str_q;
        pat_d         = pat_q;
        slen_d        = slen_q;
        plen_d        = plen_q;
        b_d           = b_q;
        count_d       = count_q;
        hit_d         = hit_q;
        o_valid_d     = o_valid_q;
        match_d       = match_q;
        o_last_d      = o_last_q;
        match_index_d = match_index_q;
        handshake_s   = o_valid_q & bus.o_ready;
        hit_rem_s     = hit_q & (hit_q - NUM_PE'(1));
        count_inc_s   = (count_q == {STR_ADD{1'b1}}) ? count_q : (count_q + STR_ADD'(1));
        // Signed "b+NUM_PE > slen-plen" rewritten without subtraction; also true when plen > slen
        last_group_s  = (b_q + CW'(NUM_PE) + CW'(plen_q)) > CW'(slen_q);

        case (state_q)
            S_LOAD: begin
                if (bus.ispattern) begin
                    if (plen_q < PW'(MAX_PATTERN)) begin
                        pat_d[plen_q[PA-1:0]] = bus.chardata;
                        plen_d                = plen_q + PW'(1);
                    end else begin
                        plen_d = plen_q;
                    end
                end else if (bus.isstring) begin
                    if (slen_q < SW'(MAX_STRING)) begin
                        str_d[slen_q[STR_ADD-1:0]] = bus.chardata;
                        slen_d                     = slen_q + SW'(1);
                    end else begin
                        slen_d = slen_q;
                    end
                end else if ((slen_q != SW'(0)) && (plen_q != PW'(0))) begin
                    state_d = S_SCAN;
                    b_d     = CW'(0);
                    count_d = STR_ADD'(0);
                    hit_d   = NUM_PE'(0);
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SCAN: begin
                hit_d = scan_hit_s;
                if (scan_hit_s != NUM_PE'(0)) begin
                    state_d       = S_EMIT;
                    o_valid_d     = 1'b1;
                    match_d       = 1'b1;
                    o_last_d      = 1'b0;
                    match_index_d = STR_ADD'(b_q + lowest_set(scan_hit_s));
                end else if (last_group_s) begin
                    state_d       = S_TERM;
                    o_valid_d     = 1'b1;
                    match_d       = 1'b0;
                    o_last_d      = 1'b1;
                    match_index_d = count_q;
                end else begin
                    b_d = b_q + CW'(NUM_PE);
                end
            end
            S_EMIT: begin
                if (handshake_s) begin
                    hit_d   = hit_rem_s;
                    count_d = count_inc_s;
                    if (hit_rem_s != NUM_PE'(0)) begin
                        match_index_d = STR_ADD'(b_q + lowest_set(hit_rem_s));
                    end else if (last_group_s) begin
                        state_d       = S_TERM;
                        match_d       = 1'b0;
                        o_last_d      = 1'b1;
                        match_index_d = count_inc_s;
                    end else begin
                        state_d       = S_SCAN;
                        b_d           = b_q + CW'(NUM_PE);
                        o_valid_d     = 1'b0;
                        match_d       = 1'b0;
                        match_index_d = STR_ADD'(0);
                    end
                end else begin
                    hit_d = hit_q;
                end
            end
            S_TERM: begin
                if (handshake_s) begin
                    state_d       = S_LOAD;
                    slen_d        = SW'(0);
                    plen_d        = PW'(0);
                    o_valid_d     = 1'b0;
                    o_last_d      = 1'b0;
                    match_index_d = STR_ADD'(0);
                end else begin
                    state_d = S_TERM;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        busy_d = (state_d != S_LOAD);
    end

    // State, buffers and registered outputs; reset drops any pending beat
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            slen_q        <= SW'(0);
            plen_q        <= PW'(0);
            b_q           <= CW'(0);
            count_q       <= STR_ADD'(0);
            hit_q         <= NUM_PE'(0);
            o_valid_q     <= 1'b0;
            match_q       <= 1'b0;
            o_last_q      <= 1'b0;
            busy_q        <= 1'b0;
            match_index_q <= STR_ADD'(0);
        end else begin
            state_q       <= state_d;
            str_q         <= str_d;
            pat_q         <= pat_d;
            slen_q        <= slen_d;
            plen_q        <= plen_d;
            b_q           <= b_d;
            count_q       <= count_d;
            hit_q         <= hit_d;
            o_valid_q     <= o_valid_d;
            match_q       <= match_d;
            o_last_q      <= o_last_d;
            busy_q        <= busy_d;
            match_index_q <= match_index_d;
        end
    end

    assign bus.o_valid     = o_valid_q;
    assign bus.match       = match_q;
    assign bus.o_last      = o_last_q;
    assign bus.busy        = busy_q;
    assign bus.match_index = match_index_q;
endmodule

// File: tb/tb_sme_multi_match.sv
// Scoreboard bench for sme_multi_match: reference model derives expected beats (and,
// with o_ready held high, their cycles) from the loaded string/pattern.
module tb_sme_multi_match;
    localparam int BYTE = 8, MAX_STRING = 32, MAX_PATTERN = 8, NUM_PE = 4, STR_ADD = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rmode = 0;

    typedef struct { bit m; int idx; bit last; int cyc; } beat_t;
    typedef struct { bit s; bit p; byte ch; } step_t;
    beat_t sb[$];
    step_t steps[$];

    sme_multi_match_if #(.BYTE(BYTE), .STR_ADD(STR_ADD)) bus ();

    sme_multi_match #(
        .BYTE(BYTE), .MAX_STRING(MAX_STRING), .MAX_PATTERN(MAX_PATTERN),
        .NUM_PE(NUM_PE), .STR_ADD(STR_ADD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ch_match(byte s, byte p);
`ifdef SME_WILDCARD_EN
        if (p == 8'h2E) return 1'b1;
`endif
        return s == p;
    endfunction

    // Reference: apply load rules, find every match, then lay out beats group by group
    task automatic build_expect(input int c_idle, input bit timed);
        byte mstr[$];
        byte mpat[$];
        int  hits[$];
        int  slen, plen, cnt, t, b, mi, h;
        bit  ok;
        foreach (steps[i]) begin
            if (steps[i].p) begin
                if (mpat.size() < MAX_PATTERN) mpat.push_back(steps[i].ch);
            end else if (steps[i].s) begin
                if (mstr.size() < MAX_STRING) mstr.push_back(steps[i].ch);
            end
        end
        slen = mstr.size();
        plen = mpat.size();
        for (int p = 0; p + plen <= slen; p++) begin
            ok = 1'b1;
            for (int j = 0; j < plen; j++) if (!ch_match(mstr[p+j], mpat[j])) ok = 1'b0;
            if (ok) hits.push_back(p);
        end
        cnt = (hits.size() > (2**STR_ADD - 1)) ? (2**STR_ADD - 1) : hits.size();
        t = c_idle + 1;
        b = 0;
        mi = 0;
        while (1) begin
            h = 0;
            while (mi < hits.size() && hits[mi] < b + NUM_PE) begin
                sb.push_back('{1'b1, hits[mi], 1'b0, timed ? t + 1 + h : -1});
                mi++;
                h++;
            end
            if (b + NUM_PE > slen - plen) begin
                sb.push_back('{1'b0, cnt, 1'b1, timed ? t + h + 1 : -1});
                break;
            end
            t = t + h + 1;
            b += NUM_PE;
        end
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) steps.push_back('{1'b1, 1'b0, s[i]});
    endtask

    task automatic add_pat(input string s);
        for (int i = 0; i < s.len(); i++) steps.push_back('{1'b0, 1'b1, s[i]});
    endtask

    task automatic run_load(output int c_idle);
        foreach (steps[i]) begin
            bus.isstring  = steps[i].s;
            bus.ispattern = steps[i].p;
            bus.chardata  = steps[i].ch;
            @(posedge clk); #1;
            if (!steps[i].s && !steps[i].p) chk("load_idle_busy", bus.busy, 0);
        end
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.chardata  = 8'h00;
        c_idle = cyc;
    endtask

    task automatic run_txn(input int mode);
        int  c;
        bit  done;
        rmode = mode;
        run_load(c);
        build_expect(c, mode == 0);
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !bus.o_valid) done = 1'b1;
        end
        chk("txn_complete", done, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_valid", bus.o_valid, 0);
        sb.delete();
    endtask

    function automatic byte rand_ch();
        int r;
        r = $urandom_range(0, 9);
        return (r < 5) ? 8'h41 : (r < 9) ? 8'h42 : 8'h2E;
    endfunction

    // Consumer: mode 0 always ready, 1 random, 2 five stalls per beat, 3 never ready
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.o_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: bus.o_ready = 1'b1;
                1: bus.o_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.o_valid && wait_cnt < 5) begin
                        bus.o_ready = 1'b0;
                        wait_cnt++;
                    end else if (bus.o_valid) begin
                        bus.o_ready = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        bus.o_ready = 1'b0;
                        wait_cnt = 0;
                    end
                end
                default: bus.o_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on each handshake, and checks a stalled beat stays put
    initial begin
        bit    held;
        beat_t hb;
        beat_t e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", bus.o_valid, 1);
                    chk("hold_match", bus.match, hb.m);
                    chk("hold_index", bus.match_index, hb.idx);
                    chk("hold_last", bus.o_last, hb.last);
                end
                if (bus.o_valid && bus.o_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got index %0d with no beat expected", bus.match_index);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_match", bus.match, e.m);
                        chk("beat_index", bus.match_index, e.idx);
                        chk("beat_last", bus.o_last, e.last);
                        if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
                    end
                    held = 1'b0;
                end else if (bus.o_valid) begin
                    held = 1'b1;
                    hb = '{bus.match, int'(bus.match_index), bus.o_last, -1};
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        int  c, ns, np, r;
        byte ch;
        bit  seen;
        bus.chardata  = 8'h00;
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_match", bus.match, 0);
        chk("rst_index", bus.match_index, 0);
        chk("rst_last", bus.o_last, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        steps.delete(); add_str("ABCABCAB"); add_pat("ABC"); run_txn(0);
        steps.delete(); add_str("AAAA"); add_pat("AA"); run_txn(0);
        steps.delete(); add_str("ABCD"); add_pat("XY"); run_txn(0);
        steps.delete(); add_str("AB");
        steps.push_back('{1'b0, 1'b0, 8'h00}); steps.push_back('{1'b0, 1'b0, 8'h00});
        add_pat("ABC"); run_txn(0);
        steps.delete(); add_str("ABCABCAB"); add_pat("ABC"); run_txn(2);
        steps.delete(); add_str("AXCAYC"); add_pat("A.C"); run_txn(0);
        steps.delete(); for (int i = 0; i < MAX_STRING + 2; i++) add_str("A");
        add_pat("A"); run_txn(0);

        // Reset while a match beat is stalled
        steps.delete(); add_str("ABCABCAB"); add_pat("ABC");
        rmode = 3;
        run_load(c);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.o_valid;
        end
        chk("pre_reset_valid", bus.o_valid, 1);
        chk("pre_reset_match", bus.match, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_reset_valid", bus.o_valid, 0);
        chk("post_reset_busy", bus.busy, 0);
        run_txn(0);

        for (int t = 0; t < 40; t++) begin
            steps.delete();
            ns = $urandom_range(1, MAX_STRING + 3);
            np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_PATTERN + 2) : $urandom_range(1, 3);
            for (int i = $urandom_range(0, 2); i > 0; i--) steps.push_back('{1'b0, 1'b0, 8'h00});
            while (ns > 0 || np > 0) begin
                r  = $urandom_range(0, 7);
                ch = rand_ch();
                if (np > 0 && (ns == 0 || r < 3)) begin
                    steps.push_back('{(r == 0) && (ns > 0), 1'b1, ch});
                    np--;
                end else begin
                    steps.push_back('{1'b1, 1'b0, ch});
                    ns--;
                end
            end
            run_txn($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
